// File: rtl/conv_bitplane_accum_pkg.sv
// Shared definitions for the conv bit-slice sequencers: state encoding,
// default pixel width and the LUT interface geometry.
package conv_bitplane_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLICE = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int PIX_W_DEF = 8;
  localparam int LUT_IN    = 4;
  localparam int LUT_OUT_W = 2;

  // Max sum is 3*(2^pix_w-1), which fits in pix_w+2 bits.
  function automatic int acc_width(input int pix_w);
    return pix_w + LUT_OUT_W;
  endfunction

endpackage

// File: rtl/conv_plane_select.sv
// Picks bit idx out of each of the LUT_IN packed pixels; pixel n sits at
// [n*PIX_W +: PIX_W] and lands on sel[n].
module conv_plane_select
  import conv_bitplane_accum_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = 3
) (
  input  logic [LUT_IN*PIX_W-1:0] pix,
  input  logic [CNT_W-1:0]        idx,
  output logic [LUT_IN-1:0]       sel
);

  always_comb begin
    sel = '0;
    for (int n = 0; n < LUT_IN; n++) begin
      sel[n] = pix[n*PIX_W + int'(idx)];
    end
  end

endmodule

// File: rtl/conv_bitplane_accum.sv
// Bit-plane sequencer: walks four pixels MSB plane first through the conv
// bit-slice LUT and shift-accumulates the 2-bit LUT results.
//
// state | meaning
// IDLE  | waiting for a pixel group, in_ready=1
// SLICE | one plane per cycle, planes PIX_W-1..0, LUT result accumulated
// DONE  | result held on out_data until out_ready; may take next group
module conv_bitplane_accum
  import conv_bitplane_accum_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int ACC_W = acc_width(PIX_W),
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LUT_IN*PIX_W-1:0] in_pix,
  output logic                    plane_bit_1,
  output logic                    plane_bit_2,
  output logic                    plane_bit_3,
  output logic                    plane_bit_4,
  output logic [CNT_W-1:0]        plane_idx,
  output logic                    plane_valid,
  input  logic [LUT_OUT_W-1:0]    lut_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data
);

  localparam logic [CNT_W-1:0] TOP_PLANE = CNT_W'(PIX_W - 1);

  conv_state_t              state;
  logic [LUT_IN*PIX_W-1:0]  pix_q;
  logic [ACC_W-1:0]         acc;
  logic [LUT_IN-1:0]        sel;

  conv_plane_select #(
    .PIX_W (PIX_W),
    .CNT_W (CNT_W)
  ) u_plane_select (
    .pix (pix_q),
    .idx (plane_idx),
    .sel (sel)
  );

  // Gating with plane_valid keeps idle LUT reads at address 0.
  assign plane_bit_1 = sel[0] & plane_valid;
  assign plane_bit_2 = sel[1] & plane_valid;
  assign plane_bit_3 = sel[2] & plane_valid;
  assign plane_bit_4 = sel[3] & plane_valid;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_q       <= '0;
      acc         <= '0;
      plane_idx   <= TOP_PLANE;
      plane_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pix_q       <= in_pix;
            acc         <= '0;
            plane_idx   <= TOP_PLANE;
            plane_valid <= 1'b1;
            state       <= SLICE;
          end
        end
        SLICE: begin
          acc <= (acc << 1) + {{(ACC_W-LUT_OUT_W){1'b0}}, lut_dout};
          if (plane_idx == '0) begin
            plane_idx   <= TOP_PLANE;
            plane_valid <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            plane_idx <= plane_idx - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              pix_q       <= in_pix;
              acc         <= '0;
              plane_idx   <= TOP_PLANE;
              plane_valid <= 1'b1;
              state       <= SLICE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          plane_valid <= 1'b0;
          out_valid   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bitplane_accum.sv
// Bench for conv_bitplane_accum: a 16-entry LUT table in the bench answers
// plane reads; results are compared with sum_k lut[addr_k] * 2^k.
module tb_conv_bitplane_accum;

  localparam int PIX_W = 8;
  localparam int ACC_W = PIX_W + 2;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4*PIX_W-1:0] in_pix = '0;
  logic             plane_bit_1, plane_bit_2, plane_bit_3, plane_bit_4;
  logic [CNT_W-1:0] plane_idx;
  logic             plane_valid;
  logic [1:0]       lut_dout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_data;

  logic [1:0] lut_tab [16];

  int total = 0;
  int bad   = 0;

  conv_bitplane_accum #(.PIX_W(PIX_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pix      (in_pix),
    .plane_bit_1 (plane_bit_1),
    .plane_bit_2 (plane_bit_2),
    .plane_bit_3 (plane_bit_3),
    .plane_bit_4 (plane_bit_4),
    .plane_idx   (plane_idx),
    .plane_valid (plane_valid),
    .lut_dout    (lut_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    lut_dout = 2'bxx;
    if (plane_valid) lut_dout = lut_tab[{plane_bit_4, plane_bit_3, plane_bit_2, plane_bit_1}];
  end

  typedef struct {
    logic [31:0] pix;
    int          lut;   // 0..3: LUT tied to that value, 4: majority-style rule
    int          exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_const(input int c);
    for (int a = 0; a < 16; a++) lut_tab[a] = 2'(c);
  endtask

  // dout_bit1 set only for addresses {b4,b3,b2,b1} = 1101, 1110, 1111
  task automatic fill_rule();
    for (int a = 0; a < 16; a++) lut_tab[a] = (a >= 13) ? 2'b01 : 2'b00;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 16; a++) lut_tab[a] = 2'($urandom_range(0, 3));
  endtask

  function automatic int model(input logic [31:0] pix);
    int s = 0;
    for (int k = 0; k < PIX_W; k++) begin
      s += int'(lut_tab[{pix[24+k], pix[16+k], pix[8+k], pix[k]}]) * (1 << k);
    end
    return s;
  endfunction

  task automatic accept(input logic [31:0] pix);
    int n = 0;
    in_valid = 1'b1;
    in_pix   = pix;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Entered at the negedge right after the accepting edge.
  task automatic slice_and_result(input logic [31:0] pix, input int exp,
                                  input bit noise, input int stall);
    for (int k = PIX_W - 1; k >= 0; k--) begin
      chk("plane_valid", int'(plane_valid), 1);
      chk("plane_idx", int'(plane_idx), k);
      chk("plane_bits", int'({plane_bit_4, plane_bit_3, plane_bit_2, plane_bit_1}),
          int'({pix[24+k], pix[16+k], pix[8+k], pix[k]}));
      chk("in_ready_busy", int'(in_ready), 0);
      chk("out_valid_early", int'(out_valid), 0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_pix   = $urandom;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("out_valid", int'(out_valid), 1);
    chk("out_data", int'(out_data), exp);
    chk("plane_valid_done", int'(plane_valid), 0);
    chk("plane_bits_done", int'({plane_bit_4, plane_bit_3, plane_bit_2, plane_bit_1}), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), exp);
      chk("stall_in_ready", int'(in_ready), 0);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_idle", int'(in_ready), 1);
  endtask

  task automatic run_op(input logic [31:0] pix, input int exp, input bit noise, input int stall);
    accept(pix);
    slice_and_result(pix, exp, noise, stall);
    release_result();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_plane_valid"}, int'(plane_valid), 0);
    chk({tag, "_plane_idx"}, int'(plane_idx), PIX_W - 1);
    chk({tag, "_plane_bits"}, int'({plane_bit_4, plane_bit_3, plane_bit_2, plane_bit_1}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa, pb;
    int ea, eb;

    vecs[0] = '{pix: $urandom,        lut: 1, exp: 255};
    vecs[1] = '{pix: 32'h1234_5678,   lut: 1, exp: 255};
    vecs[2] = '{pix: $urandom,        lut: 3, exp: 765};
    vecs[3] = '{pix: $urandom,        lut: 0, exp: 0};
    vecs[4] = '{pix: 32'hFFFF_F00F,   lut: 4, exp: 255};
    vecs[5] = '{pix: 32'hFF0F_FFFF,   lut: 4, exp: 15};

    fill_const(0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_rst");

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].lut == 4) fill_rule();
      else fill_const(vecs[i].lut);
      run_op(vecs[i].pix, vecs[i].exp, 1'b0, 0);
    end

    // Backpressure in DONE, then back-to-back accept on the releasing edge.
    fill_rule();
    pa = $urandom;
    pb = $urandom;
    ea = model(pa);
    eb = model(pb);
    accept(pa);
    slice_and_result(pa, ea, 1'b0, 5);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pix    = pb;
    #1;
    chk("b2b_in_ready", int'(in_ready), 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_out_valid_drop", int'(out_valid), 0);
    slice_and_result(pb, eb, 1'b0, 0);
    release_result();

    // Reset while plane 4 is on the LUT.
    fill_const(1);
    accept($urandom);
    repeat (3) @(negedge clk);
    chk("mid_plane_idx", int'(plane_idx), 4);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_valid", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_release");
    fill_rule();
    pa = $urandom;
    run_op(pa, model(pa), 1'b0, 0);

    // in_valid wiggling during SLICE with changing pixels.
    fill_random();
    pa = $urandom;
    run_op(pa, model(pa), 1'b1, 1);

    for (int r = 0; r < 25; r++) begin
      fill_random();
      pa = $urandom;
      run_op(pa, model(pa), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
